// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: counter-based vbars/hbars/checker/solid pattern generator with frame-synchronous mode switch.
// Syncs and DE travel through the same 2-stage pipe as RGB so all outputs stay co-aligned.
module vga_pattern_gen #(
  parameter int   H_W      = 11,
  parameter int   V_W      = 10,
  parameter int   COLOR_W  = 4,
  parameter int   BAR_W    = 128,
  parameter int   BAR_H    = 64,
  parameter int   NUM_BARS = 8,
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 display_on_i,
  input  logic [H_W-1:0]       hpos_i,
  input  logic [V_W-1:0]       vpos_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic [1:0]           mode_i,
  input  logic [3*COLOR_W-1:0] solid_rgb_i,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output logic [COLOR_W-1:0]   r_o,
  output logic [COLOR_W-1:0]   g_o,
  output logic [COLOR_W-1:0]   b_o,
  output logic [1:0]           mode_o
);
  localparam int PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int LN_W = (BAR_H > 1) ? $clog2(BAR_H) : 1;
  localparam int RGB_W = 3 * COLOR_W;
  logic [PX_W-1:0]  r_px_cnt;
  logic [LN_W-1:0]  r_ln_cnt;
  logic [2:0]       r_col_idx, r_row_idx;
  logic [1:0]       r_mode_q;
  logic             r_de_d, r_vs_d;
  logic             r_s1_de, r_s1_hs, r_s1_vs;
  logic [RGB_W-1:0] r_s1_rgb;
  logic             r_de, r_hs, r_vs;
  logic [RGB_W-1:0] r_rgb;
  logic             w_vs_edge, w_line_end;
  logic [2:0]       w_idx;
  logic [RGB_W-1:0] w_bar, w_chk, w_rgb;
  logic             w_unused;
  assign w_unused   = ^{hpos_i, vpos_i};
  assign w_vs_edge  = (vsync_i == SYNC_ACT) && (r_vs_d != SYNC_ACT);
  assign w_line_end = r_de_d && !display_on_i;
  assign w_idx = (r_mode_q == 2'd0) ? r_col_idx : r_row_idx;
  assign w_bar = {{COLOR_W{w_idx[2]}}, {COLOR_W{w_idx[1]}}, {COLOR_W{w_idx[0]}}};
  assign w_chk = {RGB_W{r_col_idx[0] ^ r_row_idx[0]}};
  assign w_rgb = (r_mode_q == 2'd3) ? solid_rgb_i : (r_mode_q == 2'd2) ? w_chk : w_bar;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_px_cnt  <= '0;
      r_col_idx <= '0;
      r_ln_cnt  <= '0;
      r_row_idx <= '0;
      r_mode_q  <= '0;
      r_de_d    <= 1'b0;
      r_vs_d    <= SYNC_ACT;
      r_s1_de   <= 1'b0;
      r_s1_hs   <= ~SYNC_ACT;
      r_s1_vs   <= ~SYNC_ACT;
      r_s1_rgb  <= '0;
      r_de      <= 1'b0;
      r_hs      <= ~SYNC_ACT;
      r_vs      <= ~SYNC_ACT;
      r_rgb     <= '0;
    end else begin
      r_de_d <= display_on_i;
      r_vs_d <= vsync_i;
      if (!display_on_i) begin
        r_px_cnt  <= '0;
        r_col_idx <= '0;
      end else if (r_px_cnt == PX_W'(BAR_W - 1)) begin
        r_px_cnt  <= '0;
        r_col_idx <= (r_col_idx == 3'(NUM_BARS - 1)) ? 3'd0 : r_col_idx + 3'd1;
      end else begin
        r_px_cnt <= r_px_cnt + 1'b1;
      end
      // Frame start beats a coincident line end.
      if (w_vs_edge) begin
        r_ln_cnt  <= '0;
        r_row_idx <= '0;
        r_mode_q  <= mode_i;
      end else if (w_line_end) begin
        if (r_ln_cnt == LN_W'(BAR_H - 1)) begin
          r_ln_cnt  <= '0;
          r_row_idx <= (r_row_idx == 3'(NUM_BARS - 1)) ? 3'd0 : r_row_idx + 3'd1;
        end else begin
          r_ln_cnt <= r_ln_cnt + 1'b1;
        end
      end
      r_s1_de  <= display_on_i;
      r_s1_hs  <= hsync_i;
      r_s1_vs  <= vsync_i;
      r_s1_rgb <= w_rgb;
      r_de     <= r_s1_de;
      r_hs     <= r_s1_hs;
      r_vs     <= r_s1_vs;
      r_rgb    <= r_s1_de ? r_s1_rgb : '0;
    end
  end
  assign hsync_o = r_hs;
  assign vsync_o = r_vs;
  assign de_o    = r_de;
  assign r_o     = r_rgb[RGB_W-1 -: COLOR_W];
  assign g_o     = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign b_o     = r_rgb[COLOR_W-1:0];
  assign mode_o  = r_mode_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed checks of reset, vbars, hbars, checker, frame-synchronous mode switch and NUM_BARS=3 wrap.
module tb_vga_pattern_gen;
  localparam logic SA = 1'b0;
  logic        clk = 1'b0;
  logic        rst;
  logic        de_i, hs_i, vs_i;
  logic [1:0]  mode_i;
  logic [11:0] solid;
  logic        hs1, vs1, de1, hs2, vs2, de2;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic [1:0]  m1, m2;
  logic [11:0] cap1 [0:1023];
  logic [11:0] cap2 [0:1023];
  logic        cap_de [0:1023];
  logic        cap_hs [0:1023];
  logic [11:0] ln1 [0:511];
  logic [11:0] ln2 [0:511];
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  vga_pattern_gen dut1 (
    .clk_i(clk), .reset_i(rst), .display_on_i(de_i), .hpos_i(11'd0), .vpos_i(10'd0),
    .hsync_i(hs_i), .vsync_i(vs_i), .mode_i(mode_i), .solid_rgb_i(solid),
    .hsync_o(hs1), .vsync_o(vs1), .de_o(de1), .r_o(r1), .g_o(g1), .b_o(b1), .mode_o(m1)
  );
  vga_pattern_gen #(.NUM_BARS(3)) dut2 (
    .clk_i(clk), .reset_i(rst), .display_on_i(de_i), .hpos_i(11'd0), .vpos_i(10'd0),
    .hsync_i(hs_i), .vsync_i(vs_i), .mode_i(mode_i), .solid_rgb_i(solid),
    .hsync_o(hs2), .vsync_o(vs2), .de_o(de2), .r_o(r2), .g_o(g2), .b_o(b2), .mode_o(m2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Each tick shows the outputs for the cycle driven one iteration earlier.
  task automatic run_line(input int act, input int blank);
    for (int i = 0; i < act + blank; i++) begin
      de_i = (i < act);
      hs_i = (i >= act + 2 && i < act + 6) ? SA : ~SA;
      vs_i = ~SA;
      tick;
      if (i > 0) begin
        cap1[i-1]   = {r1, g1, b1};
        cap2[i-1]   = {r2, g2, b2};
        cap_de[i-1] = de1;
        cap_hs[i-1] = hs1;
      end
    end
  endtask
  task automatic frame_start;
    de_i = 1'b0;
    hs_i = ~SA;
    vs_i = SA;
    tick;
    vecs++;
    if (vs1 !== ~SA) begin errs++; $display("FAIL vsync_lag1: got %b want %b", vs1, ~SA); end
    tick;
    vecs++;
    if (vs1 !== SA) begin errs++; $display("FAIL vsync_lag2: got %b want %b", vs1, SA); end
    vs_i = ~SA;
    repeat (3) tick;
  endtask
  task automatic test_reset;
    rst = 1'b1; de_i = 1'b1; hs_i = SA; vs_i = SA; mode_i = 2'd0; solid = 12'h000;
    repeat (3) tick;
    vecs += 6;
    if (de1 !== 1'b0) begin errs++; $display("FAIL rst_de: got %b want 0", de1); end
    if ({r1, g1, b1} !== 12'h000) begin errs++; $display("FAIL rst_rgb: got %h want 000", {r1, g1, b1}); end
    if (hs1 !== ~SA || hs2 !== ~SA) begin errs++; $display("FAIL rst_hs: got %b/%b want %b", hs1, hs2, ~SA); end
    if (vs1 !== ~SA || vs2 !== ~SA) begin errs++; $display("FAIL rst_vs: got %b/%b want %b", vs1, vs2, ~SA); end
    if (m1 !== 2'd0) begin errs++; $display("FAIL rst_mode: got %0d want 0", m1); end
    if (de2 !== 1'b0) begin errs++; $display("FAIL rst_de2: got %b want 0", de2); end
    rst = 1'b0; hs_i = ~SA; vs_i = ~SA;
    tick;
    vecs++;
    if (de1 !== 1'b0) begin errs++; $display("FAIL de_lag1: got %b want 0", de1); end
    tick;
    vecs += 2;
    if (de1 !== 1'b1) begin errs++; $display("FAIL de_lag2: got %b want 1", de1); end
    if ({r1, g1, b1} !== 12'h000) begin errs++; $display("FAIL first_px: got %h want 000", {r1, g1, b1}); end
    de_i = 1'b0;
    repeat (4) tick;
  endtask
  task automatic test_vbars;
    int          ix [7] = '{0, 127, 128, 256, 384, 512, 639};
    logic [11:0] ex [7] = '{12'h000, 12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF00};
    int          jx [5] = '{0, 128, 256, 384, 512};
    logic [11:0] fx [5] = '{12'h000, 12'h00F, 12'h0F0, 12'h000, 12'h00F};
    mode_i = 2'd0;
    frame_start;
    run_line(640, 16);
    for (int k = 0; k < 7; k++) begin
      vecs++;
      if (cap1[ix[k]] !== ex[k]) begin errs++; $display("FAIL vbars px%0d: got %h want %h", ix[k], cap1[ix[k]], ex[k]); end
    end
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if (cap2[jx[k]] !== fx[k]) begin errs++; $display("FAIL vbars3 px%0d: got %h want %h", jx[k], cap2[jx[k]], fx[k]); end
    end
    vecs += 5;
    if (cap_de[639] !== 1'b1) begin errs++; $display("FAIL de_last: got %b want 1", cap_de[639]); end
    if (cap_de[640] !== 1'b0) begin errs++; $display("FAIL de_end: got %b want 0", cap_de[640]); end
    if (cap_hs[641] !== ~SA) begin errs++; $display("FAIL hs_pre: got %b want %b", cap_hs[641], ~SA); end
    if (cap_hs[642] !== SA) begin errs++; $display("FAIL hs_act: got %b want %b", cap_hs[642], SA); end
    if (cap2[642] !== 12'h000) begin errs++; $display("FAIL blank3: got %h want 000", cap2[642]); end
  endtask
  task automatic test_hbars;
    int          ix [5] = '{0, 63, 64, 128, 448};
    logic [11:0] ex [5] = '{12'h000, 12'h000, 12'h00F, 12'h0F0, 12'hFFF};
    int          jx [3] = '{64, 128, 192};
    logic [11:0] fx [3] = '{12'h00F, 12'h0F0, 12'h000};
    mode_i = 2'd1;
    frame_start;
    for (int l = 0; l < 480; l++) begin
      run_line(4, 8);
      ln1[l] = cap1[0];
      ln2[l] = cap2[0];
    end
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if (ln1[ix[k]] !== ex[k]) begin errs++; $display("FAIL hbars ln%0d: got %h want %h", ix[k], ln1[ix[k]], ex[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (ln2[jx[k]] !== fx[k]) begin errs++; $display("FAIL hbars3 ln%0d: got %h want %h", jx[k], ln2[jx[k]], fx[k]); end
    end
    vecs++;
    if (m1 !== 2'd1) begin errs++; $display("FAIL hbars_mode: got %0d want 1", m1); end
    frame_start;
    run_line(4, 8);
    vecs++;
    if (cap1[0] !== 12'h000) begin errs++; $display("FAIL hbars_restart: got %h want 000", cap1[0]); end
  endtask
  task automatic test_checker;
    mode_i = 2'd2;
    frame_start;
    run_line(640, 16);
    vecs += 3;
    if (cap1[0] !== 12'h000) begin errs++; $display("FAIL chk l0p0: got %h want 000", cap1[0]); end
    if (cap1[128] !== 12'hFFF) begin errs++; $display("FAIL chk l0p128: got %h want FFF", cap1[128]); end
    if (cap1[256] !== 12'h000) begin errs++; $display("FAIL chk l0p256: got %h want 000", cap1[256]); end
    for (int l = 1; l < 64; l++) run_line(4, 8);
    run_line(640, 16);
    vecs += 2;
    if (cap1[0] !== 12'hFFF) begin errs++; $display("FAIL chk l64p0: got %h want FFF", cap1[0]); end
    if (cap1[128] !== 12'h000) begin errs++; $display("FAIL chk l64p128: got %h want 000", cap1[128]); end
  endtask
  task automatic test_mode_switch;
    mode_i = 2'd0;
    frame_start;
    repeat (200) run_line(4, 8);
    mode_i = 2'd3;
    solid = 12'hA5C;
    run_line(640, 16);
    vecs += 3;
    if (cap1[0] !== 12'h000) begin errs++; $display("FAIL sw_hold p0: got %h want 000", cap1[0]); end
    if (cap1[128] !== 12'h00F) begin errs++; $display("FAIL sw_hold p128: got %h want 00F", cap1[128]); end
    if (m1 !== 2'd0) begin errs++; $display("FAIL sw_mode_hold: got %0d want 0", m1); end
    frame_start;
    vecs += 2;
    if (m1 !== 2'd3) begin errs++; $display("FAIL sw_mode_new: got %0d want 3", m1); end
    if (m2 !== 2'd3) begin errs++; $display("FAIL sw_mode_new2: got %0d want 3", m2); end
    run_line(640, 16);
    vecs += 4;
    if (cap1[0] !== 12'hA5C) begin errs++; $display("FAIL solid p0: got %h want A5C", cap1[0]); end
    if (cap1[500] !== 12'hA5C) begin errs++; $display("FAIL solid p500: got %h want A5C", cap1[500]); end
    if (cap1[643] !== 12'h000) begin errs++; $display("FAIL solid_blank: got %h want 000", cap1[643]); end
    if (cap_de[643] !== 1'b0) begin errs++; $display("FAIL solid_blank_de: got %b want 0", cap_de[643]); end
  endtask
  initial begin
    test_reset;
    test_vbars;
    test_hbars;
    test_checker;
    test_mode_switch;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
